// File: rtl/vector_subtractor_if.sv
// Operand/result bundle between the operand sequencer (master) and the subtract lane (slave).
interface vector_subtractor_if #(
    parameter int unsigned WIDTH = 24
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             last;
    logic             busy;
    logic             done;

    modport master (
        output start, in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, last, busy, done
    );

    modport slave (
        input  start, in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, last, busy, done
    );
endinterface

// File: rtl/vector_subtractor.sv
// Streaming element-wise subtractor: VLEN operand pairs in, one registered a-b (+borrow) per pair out.
// Define VSUB_SATURATE_EN to clamp negative differences to zero instead of wrapping.
module vector_subtractor #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned VLEN  = 8
) (
    input logic                clk,
    input logic                rst_n,
    vector_subtractor_if.slave vs
);
    localparam int unsigned      CW      = $clog2(VLEN + 1);
    localparam logic [CW-1:0]    LastIdx = CW'(VLEN - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e           r_state, w_state_next;
    logic [CW-1:0]    r_count, w_count_next;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_last;
    logic             r_done;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_consume;
    logic             w_borrow;
    logic [WIDTH-1:0] w_diff;

    assign w_accept  = vs.in_valid & w_in_ready;
    assign w_consume = r_out_valid & vs.out_ready;
    assign w_borrow  = (vs.a < vs.b);

`ifdef VSUB_SATURATE_EN
    assign w_diff = w_borrow ? '0 : (vs.a - vs.b);
`else
    assign w_diff = vs.a - vs.b;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        unique case (r_state)
            StIdle: begin
                if (vs.start) begin
                    w_state_next = StRun;
                    w_count_next = '0;
                end
            end
            StRun: begin
                if (w_accept) begin
                    w_count_next = r_count + 1'b1;
                    if (r_count == LastIdx) w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (w_consume) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Result register: a new accept overwrites in the same cycle the old result is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
            r_last      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == StDrain) && w_consume;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_diff      <= w_diff;
                r_borrow    <= w_borrow;
                r_last      <= (r_count == LastIdx);
            end else if (w_consume) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_in_ready   = (r_state == StRun) && (!r_out_valid || vs.out_ready);
        vs.in_ready  = w_in_ready;
        vs.out_valid = r_out_valid;
        vs.diff      = r_diff;
        vs.borrow    = r_borrow;
        vs.last      = r_last;
        vs.busy      = (r_state != StIdle);
        vs.done      = r_done;
    end
endmodule

// File: doc/vector_subtractor.md
# vector_subtractor

Streaming element-wise subtract engine for the vector machine datapath: the inverse lane of the vector adder. Once started, it accepts exactly VLEN operand pairs over a valid/ready handshake and returns one registered difference per pair, in order, with a borrow flag. It sits beside the adder lane, fed by the operand sequencer, and drains into the writeback buffer.

## Interface
- WIDTH, 24, element width in bits (unsigned).
- VLEN, 8, elements per vector operation; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a vector op; honoured only in IDLE.
- in_valid  input  1  operand pair a/b valid.
- in_ready  output  1  engine accepts a/b this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  diff/borrow/last valid.
- out_ready  input  1  downstream accepts the result.
- diff  output  WIDTH  a - b (mode per Configuration).
- borrow  output  1  1 when a < b (unsigned).
- last  output  1  marks result of element VLEN-1.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse when the final result is consumed.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: in_ready=0. start=1 -> RUN, count cleared to 0.
- RUN: in_ready = !out_valid | out_ready. On in_valid & in_ready: register diff and borrow, set out_valid, set last = (count == VLEN-1), increment count. Acceptance of element VLEN-1 -> DRAIN.
- DRAIN: in_ready=0. When out_valid & out_ready (final result consumed): out_valid cleared, done pulses for 1 cycle, -> IDLE.
- Output register: the held result stays stable while out_valid=1 & out_ready=0. Simultaneous consume and accept in RUN loads the new result with out_valid remaining 1 (full throughput, no bubble).
- Arithmetic: diff = (a - b) mod 2^WIDTH; borrow = (a < b), unsigned compare on the full WIDTH.
- count width: $clog2(VLEN+1).
- start while busy: ignored. start with in_valid in the IDLE cycle: the pair is not accepted (in_ready=0).
- rst_n low at any time, including mid-vector: immediately -> IDLE, count=0, and all partial results discarded.

## Timing
- Reset values: in_ready=0, out_valid=0, diff=0, borrow=0, last=0, busy=0, done=0.
- Latency: a result is valid on the cycle after acceptance (1 clk).
- Throughput: 1 element/cycle while out_ready=1.
- busy rises on the cycle after start; it falls on the same edge that raises done.
- done rises on the edge after the final handshake and stays high for exactly 1 cycle.
- Minimum op length with no stalls: VLEN + 2 cycles from start to done.

## Configuration
- VSUB_SATURATE_EN defined: when a < b, diff = 0 and borrow = 1 (clamp at zero).
- Not defined: diff wraps modulo 2^WIDTH. borrow behaves identically in both builds.

## Test plan
- Reset mid-vector: VLEN=8, assert rst_n=0 after 3 accepts -> all outputs at reset values; the next start runs a full 8 elements.
- Wrap build, a=24'hC4100B, b=24'hC01400 -> diff=24'h03FC0B, borrow=0, 1 cycle after acceptance.
- Wrap build, a=24'hC01401, b=24'hC41403 -> diff=24'hFBFFFE, borrow=1. Saturate build, same pair -> diff=24'h000000, borrow=1.
- Back-to-back stream: 8 pairs with out_ready held at 1 -> 8 results on consecutive cycles, last=1 only on the 8th, done 1 cycle later, total 10 cycles from start.
- Backpressure: out_ready=0 for 4 cycles while holding a=24'hD0140B, b=24'hD01402 -> diff=24'h000009 held stable, in_ready=0, no element lost or duplicated.
- start asserted during RUN, and start together with in_valid in IDLE -> neither the count nor the accepted-pair total changes.
